// File: rtl/spi_master_ctrl.sv
// SPI master: sequences MSB-first byte frames in all CPOL/CPHA modes with a CLK_DIV sck divider.
// Optional macro SPI_CS_GAP_EN adds a GAP state holding cs high for CS_GAP clk cycles between frames.
module spi_master_ctrl #(
    parameter logic CPOL    = 1'b0,
    parameter logic CPHA    = 1'b0,
    parameter int   CLK_DIV = 2,
    parameter int   CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       sck,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_WAIT
`ifdef SPI_CS_GAP_EN
        , ST_GAP
`endif
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic       trail_q, trail_d;
    logic [7:0] shift_q, shift_d;
    logic       last_q, last_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       sck_q, sck_d;
    logic       cs_q, cs_d;
    logic       mosi_q, mosi_d;
    logic       half_done;
    logic       handshake;
`ifdef SPI_CS_GAP_EN
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
    logic [7:0] gap_q, gap_d;
`endif

    assign tx_ready  = !rst && ((state_q == ST_IDLE) || (state_q == ST_WAIT));
    assign handshake = tx_valid && tx_ready;
    assign half_done = (div_q == DIV_LAST);

    always_comb begin
        // NOTE: every *_d is given its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        trail_d    = trail_q;
        shift_d    = shift_q;
        last_d     = last_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sck_d      = sck_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
`ifdef SPI_CS_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (handshake) begin
                    state_d = ST_SETUP;
                    shift_d = tx_data;
                    last_d  = tx_last;
                    cs_d    = 1'b0;
                    div_d   = '0;
                    if (!CPHA) mosi_d = tx_data[7];
                end
            end
            ST_SETUP: begin
                if (half_done) begin
                    state_d = ST_XFER;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_XFER: begin
                if (!half_done) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!trail_q) begin
                        trail_d = 1'b1;
                        if (CPHA) begin
                            mosi_d  = shift_q[7];
                            shift_d = {shift_q[6:0], 1'b0};
                        end else begin
                            rx_shift_d = {rx_shift_q[6:0], miso};
                        end
                    end else begin
                        trail_d = 1'b0;
                        if (CPHA) rx_shift_d = {rx_shift_q[6:0], miso};
                        if (bit_q == 3'd0) begin
                            state_d = ST_HOLD;
                            bit_d   = 3'd7;
                        end else begin
                            bit_d = bit_q - 3'd1;
                            if (!CPHA) begin
                                mosi_d  = shift_q[6];
                                shift_d = {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (!half_done) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d      = '0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    if (last_q) begin
                        cs_d = 1'b1;
`ifdef SPI_CS_GAP_EN
                        if (CS_GAP != 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
`ifdef SPI_CS_GAP_EN
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 8'd1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written only with <= so all flops update together at the edge.
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= 3'd7;
            trail_q    <= 1'b0;
            shift_q    <= '0;
            last_q     <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sck_q      <= CPOL;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
`ifdef SPI_CS_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            trail_q    <= trail_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
`ifdef SPI_CS_GAP_EN
            gap_q      <= gap_d;
`endif
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sck      = sck_q;
    assign cs       = cs_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: five instances covering modes 0-3 and CLK_DIV=1,
// each with a behavioural SPI slave returning a fixed byte and capturing mosi.
module tb_spi_master_ctrl;

    localparam int NI = 5;
    localparam logic [NI-1:0] P_CPOL = 5'b01100;
    localparam logic [NI-1:0] P_CPHA = 5'b01010;
    localparam int P_DIV [NI] = '{2, 2, 3, 2, 1};
    localparam logic [7:0] P_SLV [NI] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hC3};
`ifdef SPI_CS_GAP_EN
    localparam int EXP_GAP_LEN  = 5;
    localparam int EXP_GAP_BUSY = 4;
`else
    localparam int EXP_GAP_LEN  = 1;
    localparam int EXP_GAP_BUSY = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data  [NI];
    logic       tx_last  [NI];
    logic       tx_valid [NI];
    logic       tx_ready [NI];
    logic [7:0] rx_data  [NI];
    logic       rx_valid [NI];
    logic       busy     [NI];
    logic       sck      [NI];
    logic       cs       [NI];
    logic       mosi     [NI];
    logic       miso     [NI];

    int cs_low_n [NI];
    int tgl_n    [NI];
    int rise_n   [NI];
    int rxv_n    [NI];
    logic [7:0] slv_rx   [NI];
    logic [7:0] slv_prev [NI];
    int slv_cnt  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        spi_master_ctrl #(
            .CPOL(P_CPOL[g]), .CPHA(P_CPHA[g]), .CLK_DIV(P_DIV[g]), .CS_GAP(4)
        ) u_dut (
            .clk(clk), .rst(rst),
            .tx_data(tx_data[g]), .tx_last(tx_last[g]), .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
            .busy(busy[g]), .sck(sck[g]), .cs(cs[g]), .mosi(mosi[g]), .miso(miso[g])
        );

        // Slave: drives P_SLV MSB first and shifts in mosi, per its CPOL/CPHA.
        logic       s_cs_p  = 1'b1;
        logic       s_sck_p = P_CPOL[g];
        logic       s_miso  = 1'b0;
        logic [7:0] s_in    = 8'h00;
        int         s_in_n  = 0;
        int         s_out_i = 0;
        assign miso[g] = s_miso;

        always @(cs[g] or sck[g]) begin
            if (s_cs_p === 1'b1 && cs[g] === 1'b0) begin
                s_in_n  = 0;
                s_out_i = 0;
                if (!P_CPHA[g]) begin
                    s_miso  = P_SLV[g][7];
                    s_out_i = 1;
                end
            end else if (cs[g] === 1'b0 && sck[g] !== s_sck_p) begin
                if ((sck[g] != P_CPOL[g]) == P_CPHA[g]) begin
                    s_miso  = P_SLV[g][7 - s_out_i];
                    s_out_i = (s_out_i + 1) % 8;
                end else begin
                    s_in   = {s_in[6:0], mosi[g]};
                    s_in_n = s_in_n + 1;
                    if (s_in_n == 8) begin
                        s_in_n       = 0;
                        slv_prev[g]  = slv_rx[g];
                        slv_rx[g]    = s_in;
                        slv_cnt[g]   = slv_cnt[g] + 1;
                    end
                end
            end
            s_cs_p  = cs[g];
            s_sck_p = sck[g];
        end

        logic m_cs  = 1'b1;
        logic m_sck = P_CPOL[g];
        always @(negedge clk) begin
            if (cs[g] === 1'b0) begin
                cs_low_n[g] = cs_low_n[g] + 1;
                if (sck[g] !== m_sck) tgl_n[g] = tgl_n[g] + 1;
            end
            if (cs[g] === 1'b1 && m_cs === 1'b0) rise_n[g] = rise_n[g] + 1;
            if (rx_valid[g] === 1'b1) rxv_n[g] = rxv_n[g] + 1;
            m_cs  = cs[g];
            m_sck = sck[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input int i, input logic [7:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        tx_data[i]  = d;
        tx_last[i]  = last;
        tx_valid[i] = 1'b1;
        while (tx_ready[i] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready_i%0d", i), {31'd0, tx_ready[i]}, 32'd1);
        @(negedge clk);
        tx_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy[i] !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_i%0d", i), {31'd0, busy[i]}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input int i, input logic [7:0] d, input string tag);
        int c0, t0, r0, s0;
        check($sformatf("%s_sck_pre", tag), {31'd0, sck[i]}, {31'd0, P_CPOL[i]});
        c0 = cs_low_n[i]; t0 = tgl_n[i]; r0 = rxv_n[i]; s0 = slv_cnt[i];
        send_byte(i, d, 1'b1);
        wait_idle(i);
        check($sformatf("%s_cs_low", tag), cs_low_n[i] - c0, 18 * P_DIV[i]);
        check($sformatf("%s_sck_edges", tag), tgl_n[i] - t0, 16);
        check($sformatf("%s_rxv_pulses", tag), rxv_n[i] - r0, 1);
        check($sformatf("%s_rx_data", tag), {24'd0, rx_data[i]}, {24'd0, P_SLV[i]});
        check($sformatf("%s_slave_bytes", tag), slv_cnt[i] - s0, 1);
        check($sformatf("%s_slave_mosi", tag), {24'd0, slv_rx[i]}, {24'd0, d});
        check($sformatf("%s_sck_post", tag), {31'd0, sck[i]}, {31'd0, P_CPOL[i]});
        check($sformatf("%s_cs_post", tag), {31'd0, cs[i]}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0, s0, n_t, hs, run, gap_len, gap_busy, bad_rdy, wn;
        logic prev;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            tx_data[i] = 8'h00; tx_last[i] = 1'b0; tx_valid[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", {31'd0, cs[0]}, 32'd1);
        check("rst_sck", {31'd0, sck[2]}, 32'd1);
        check("rst_mosi", {31'd0, mosi[0]}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data[0]}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid[0]}, 32'd0);
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tx_ready", {31'd0, tx_ready[0]}, 32'd1);

        run_frame(0, 8'h3C, "m0");
        run_frame(1, 8'h81, "m1");
        run_frame(2, 8'h81, "m2");
        run_frame(3, 8'h81, "m3");
        run_frame(4, 8'hFF, "div1_ff");
        run_frame(4, 8'h00, "div1_00");

        // Burst of two bytes on mode 0 with a host delay in WAIT.
        c0 = rise_n[0]; r0 = rxv_n[0]; s0 = slv_cnt[0];
        send_byte(0, 8'h11, 1'b0);
        wn = 0;
        while (rx_valid[0] !== 1'b1 && wn < 500) begin
            @(negedge clk);
            wn++;
        end
        check("burst_first_rxv", {31'd0, rx_valid[0]}, 32'd1);
        repeat (5) @(negedge clk);
        check("burst_wait_ready", {31'd0, tx_ready[0]}, 32'd1);
        check("burst_wait_cs", {31'd0, cs[0]}, 32'd0);
        check("burst_wait_busy", {31'd0, busy[0]}, 32'd1);
        send_byte(0, 8'h22, 1'b1);
        wait_idle(0);
        check("burst_cs_rises", rise_n[0] - c0, 1);
        check("burst_rxv_pulses", rxv_n[0] - r0, 2);
        check("burst_slave_bytes", slv_cnt[0] - s0, 2);
        check("burst_slave_b0", {24'd0, slv_prev[0]}, 32'h11);
        check("burst_slave_b1", {24'd0, slv_rx[0]}, 32'h22);
        check("burst_rx_data", {24'd0, rx_data[0]}, 32'hA5);

        // Reset at the 7th sck edge aborts the frame without rx_valid.
        r0 = rxv_n[0];
        send_byte(0, 8'h3C, 1'b1);
        n_t = 0;
        prev = sck[0];
        for (int n = 0; n < 500 && n_t < 7; n++) begin
            @(negedge clk);
            if (sck[0] !== prev) n_t++;
            prev = sck[0];
        end
        check("abort_mosi_before", {31'd0, mosi[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_cs", {31'd0, cs[0]}, 32'd1);
        check("abort_sck", {31'd0, sck[0]}, 32'd0);
        check("abort_mosi", {31'd0, mosi[0]}, 32'd0);
        check("abort_busy", {31'd0, busy[0]}, 32'd0);
        check("abort_rx_valid", {31'd0, rx_valid[0]}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_rxv", rxv_n[0] - r0, 0);
        run_frame(0, 8'h5A, "after_abort");

        // Back-to-back last=1 frames with tx_valid held high.
        hs = 0; run = 0; gap_len = -1; gap_busy = 0; bad_rdy = 0;
        @(negedge clk);
        tx_data[0] = 8'h12; tx_last[0] = 1'b1; tx_valid[0] = 1'b1;
        for (int n = 0; n < 1000 && gap_len < 0; n++) begin
            if (hs == 2) tx_valid[0] = 1'b0;
            if (cs[0] === 1'b1) begin
                if (hs >= 1) begin
                    run++;
                    if (busy[0] === 1'b1) begin
                        gap_busy++;
                        if (tx_ready[0] !== 1'b0) bad_rdy++;
                    end
                end
            end else if (run > 0) begin
                gap_len = run;
            end
            if (tx_valid[0] === 1'b1 && tx_ready[0] === 1'b1) hs++;
            @(negedge clk);
        end
        tx_valid[0] = 1'b0;
        check("b2b_cs_high_len", gap_len, EXP_GAP_LEN);
        check("b2b_gap_cycles", gap_busy, EXP_GAP_BUSY);
        check("b2b_ready_in_gap", bad_rdy, 0);
        wait_idle(0);
        check("b2b_slave_mosi", {24'd0, slv_rx[0]}, 32'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-clock SPI master that sequences byte transfers to the team's SPI slave over sck/cs/mosi/miso.
- Supports all four CPOL/CPHA modes with a programmable sck divider.
- Host side uses a valid/ready byte stream with a last flag; bursts hold cs low across bytes.
- Sits between the system bus glue and the SPI pins.

Parameters:
- CPOL, 0: sck idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- CLK_DIV, 2: clk cycles per sck half-period; legal range 1..255.
- CS_GAP, 4: minimum clk cycles cs stays high between frames. Used only with SPI_CS_GAP_EN.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send, MSB first.
- tx_last  input  1  1 = deassert cs after this byte.
- tx_valid  input  1  host offers tx_data/tx_last.
- tx_ready  output  1  controller accepts the byte this cycle.
- rx_data  output  8  last byte received on miso.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- busy  output  1  high while cs is low or a gap is pending.
- sck  output  1  SPI clock.
- cs  output  1  chip select, active low.
- mosi  output  1  master out.
- miso  input  1  slave in; sampled directly, no synchroniser.

Behaviour:
- Reset values (rst high, and the cycle after it):
  - cs=1, sck=CPOL, mosi=0, rx_data=0x00, rx_valid=0, busy=0, tx_ready=0.
  - State is IDLE, half-period counter=0, bit counter=7.
- tx_ready is a combinational decode: high in IDLE and WAIT, forced low while rst is high. It does not depend on tx_valid.
- A transfer is accepted when tx_valid and tx_ready are both high on a clk edge. tx_data and tx_last are latched into shift_reg and last_q.
- States:
  - IDLE: cs=1, sck=CPOL. On handshake go to SETUP; cs falls the next cycle.
  - SETUP: lasts CLK_DIV cycles with cs=0 and sck=CPOL. If CPHA=0, mosi=shift_reg[7] throughout SETUP. Then go to XFER.
  - XFER: sck toggles every CLK_DIV cycles, 16 edges total (8 leading, 8 trailing).
    - CPHA=0: sample miso on leading edges; shift mosi to the next bit on trailing edges, except after bit 0.
    - CPHA=1: drive the next bit on mosi at each leading edge; sample on trailing edges.
    - After the 16th edge go to HOLD.
  - HOLD: CLK_DIV cycles with sck=CPOL.
    - At exit, rx_data takes the assembled byte and rx_valid pulses for one cycle.
    - If last_q=1: go to IDLE (or GAP) and cs rises.
    - If last_q=0: go to WAIT with cs held low.
  - WAIT: cs=0, sck=CPOL, mosi holds its last value, tx_ready=1.
    - On handshake, load the new byte and go to SETUP without raising cs.
    - No timeout; WAIT persists until the host supplies a byte.
  - GAP: present only with SPI_CS_GAP_EN.
- Frame timing: cs is low for exactly (1+16+1)*CLK_DIV clk cycles per single-byte frame.
- Burst timing: bytes are separated by at least CLK_DIV clk cycles (SETUP) plus the host's handshake delay.
- busy = (state != IDLE).
- Received bits are assembled MSB first into rx_shift. The first sampled bit lands in bit 7.
- Reset mid-transfer: on the next posedge all outputs return to reset values. cs rises immediately and no rx_valid is issued for the aborted byte.
- tx_valid held without tx_ready causes no side effects. The host must keep tx_data stable until the handshake completes.

Optional Feature:
- Macro: SPI_CS_GAP_EN.
- With the macro defined:
  - After a frame ends with last_q=1, go to GAP instead of IDLE.
  - GAP holds cs=1, sck=CPOL, tx_ready=0, busy=1 for CS_GAP clk cycles, then goes to IDLE.
  - CS_GAP=0 behaves as the macro being undefined.
- Without the macro:
  - GAP logic and counter are not built.
  - tx_ready returns high in the cycle after cs rises.

Test Plan:
- Mode 0, CLK_DIV=2, slave model returns 0xA5; send 0x3C with last=1.
  - mosi bits are 0,0,1,1,1,1,0,0, each stable at its rising sck.
  - rx_data=0xA5 with a single rx_valid pulse.
  - cs low for exactly 36 clk cycles.
- Repeat the transfer for modes 1, 2, 3 with matching slave models, sending 0x81.
  - sck idles at CPOL before and after the frame.
  - rx_data=0xA5; mosi is sampled by the slave as 0x81.
- Burst: send 0x11 (last=0), then 0x22 (last=1) after a 5-cycle host delay.
  - cs stays low across both bytes.
  - tx_ready is high in WAIT.
  - Two rx_valid pulses.
- Reset asserted at the 7th sck edge of a frame.
  - Next cycle: cs=1, sck=CPOL, mosi=0, busy=0, no rx_valid.
  - A new 0x5A transfer then completes normally.
- With SPI_CS_GAP_EN and CS_GAP=4: issue back-to-back last=1 frames with tx_valid held high.
  - cs stays high for at least 4 clk cycles between frames.
  - tx_ready stays low during the gap.
- CLK_DIV=1 with 0xFF and 0x00 payloads.
  - sck toggles every clk cycle.
  - The frame is 18 clk cycles.
  - rx_data matches the slave's byte.
